// File: rtl/seg_display_periph.sv
// rtl/seg_display_periph.sv - memory-mapped 4-digit seven-segment display controller
// Optional blink support is compiled in with SEG_BLINK_EN.
module seg_display_periph #(
    parameter logic [31:0] BASE_ADDR     = 32'hFFFF_FF00,
    parameter int unsigned PRESCALE_BITS = 16,
    parameter int unsigned BLINK_BITS    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        data_rw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam logic [PRESCALE_BITS-1:0] PRE_ONE = 1;

    logic [15:0]              data_q;
    logic [3:0]               en_q;
    logic [PRESCALE_BITS-1:0] pre_q;
    logic [1:0]               idx_q;
    logic                     blink_bit;
    logic                     blink_dark;

    logic        accept;
    logic        hit;
    logic        wr_data;
    logic        wr_ctrl;
    logic        digit_tick;
    logic [31:0] ctrl_word;
    logic [31:0] rdata_d;
    logic [3:0]  onehot;
    logic [3:0]  nibble;
    logic [3:0]  an_d;
    logic [6:0]  seg_d;
    logic        unused_bits;

    // A strobe seen while ack is high belongs to the access already being completed.
    assign accept     = sel & ~ack;
    assign hit        = (addr[31:3] == BASE_ADDR[31:3]);
    assign wr_data    = accept & data_rw & hit & ~addr[2];
    assign wr_ctrl    = accept & data_rw & hit & addr[2];
    assign digit_tick = &pre_q;
    assign ctrl_word  = {23'd0, blink_bit, 4'd0, en_q};
    assign unused_bits = ^{addr[1:0], wdata[31:16]};

`ifdef SEG_BLINK_EN
    localparam logic [BLINK_BITS-1:0] BLINK_ONE = 1;

    logic                  blink_en_q;
    logic [BLINK_BITS-1:0] blink_cnt_q;
    logic                  phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_en_q  <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                blink_en_q <= wdata[8];
            end
            if (digit_tick) begin
                blink_cnt_q <= blink_cnt_q + BLINK_ONE;
                if (&blink_cnt_q) begin
                    phase_q <= ~phase_q;
                end
            end
        end
    end

    assign blink_bit  = blink_en_q;
    assign blink_dark = blink_en_q & phase_q;
`else
    localparam int unsigned unused_blink_bits = BLINK_BITS;

    assign blink_bit  = 1'b0;
    assign blink_dark = 1'b0;
`endif

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        onehot = 4'b0001 << idx_q;
        case (idx_q)
            2'd0:    nibble = data_q[3:0];
            2'd1:    nibble = data_q[7:4];
            2'd2:    nibble = data_q[11:8];
            default: nibble = data_q[15:12];
        endcase
        an_d  = ~(onehot & en_q);
        seg_d = (|(onehot & en_q)) ? hex_to_seg(nibble) : 7'b1111111;
        if (blink_dark) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        if (accept && !data_rw && hit) begin
            rdata_d = addr[2] ? ctrl_word : {16'd0, data_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 16'd0;
            en_q   <= 4'hF;
            pre_q  <= '0;
            idx_q  <= 2'd0;
            ack    <= 1'b0;
            rdata  <= 32'd0;
            an     <= 4'b1111;
            seg    <= 7'b1111111;
        end else begin
            if (wr_data) begin
                data_q <= wdata[15:0];
            end
            if (wr_ctrl) begin
                en_q <= wdata[3:0];
            end
            pre_q <= pre_q + PRE_ONE;
            if (digit_tick) begin
                idx_q <= idx_q + 2'd1;
            end
            ack   <= accept;
            rdata <= rdata_d;
            an    <= an_d;
            seg   <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_display_periph.sv
// tb/tb_seg_display_periph.sv - randomized model-checked bench for seg_display_periph
module tb_seg_display_periph;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam int PB = 2;
    localparam int BB = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        data_rw = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ack;
    logic [6:0]  seg;
    logic [3:0]  an;

    int total = 0;
    int bad = 0;

    seg_display_periph #(
        .BASE_ADDR(BASE),
        .PRESCALE_BITS(PB),
        .BLINK_BITS(BB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sel(sel),
        .data_rw(data_rw),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .ack(ack),
        .seg(seg),
        .an(an)
    );

    always #5 clk = ~clk;

`ifdef SEG_BLINK_EN
    localparam bit HAS_BLINK = 1'b1;
`else
    localparam bit HAS_BLINK = 1'b0;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    // Display for the cycle after k non-reset edges have elapsed since reset.
    function automatic logic [10:0] model_disp(input int k, input logic [15:0] d,
                                               input logic [3:0] mask, input logic blink);
        int adv;
        int digit;
        int phase;
        adv   = k / (2 ** PB);
        digit = adv % 4;
        phase = (adv / (2 ** BB)) % 2;
        if (HAS_BLINK && blink && phase == 1) return {4'hF, 7'h7F};
        if (!mask[digit]) return {4'hF, 7'h7F};
        return {~(4'(1) << digit), hex7(4'((d >> (4 * digit)) & 16'hF))};
    endfunction

    function automatic bit mhit(input logic [31:0] a);
        return (a >> 3) == (BASE >> 3);
    endfunction

    bit          started = 1'b0;
    int          k = 0;
    logic [15:0] m_data;
    logic [3:0]  m_mask;
    logic        m_blink;
    logic        exp_ack;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;

    always @(posedge clk) begin
        if (rst) begin
            started   <= 1'b1;
            k         <= 0;
            m_data    <= 16'd0;
            m_mask    <= 4'hF;
            m_blink   <= 1'b0;
            exp_ack   <= 1'b0;
            exp_rdata <= 32'd0;
            exp_an    <= 4'hF;
            exp_seg   <= 7'h7F;
        end else if (started) begin
            k <= k + 1;
            {exp_an, exp_seg} <= model_disp(k, m_data, m_mask, m_blink);
            exp_ack   <= sel && !exp_ack;
            exp_rdata <= 32'd0;
            if (sel && !exp_ack && mhit(addr)) begin
                if (data_rw) begin
                    if (addr[2]) begin
                        m_mask  <= wdata[3:0];
                        m_blink <= HAS_BLINK ? wdata[8] : 1'b0;
                    end else begin
                        m_data <= wdata[15:0];
                    end
                end else begin
                    exp_rdata <= addr[2] ? (32'(m_mask) | (32'(m_blink) << 8)) : 32'(m_data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("ack", 32'(ack), 32'(exp_ack));
            check("rdata", rdata, exp_rdata);
            check("an", 32'(an), 32'(exp_an));
            check("seg", 32'(seg), 32'(exp_seg));
        end
    end

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
        @(negedge clk);
        sel = 1'b1; data_rw = w; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0;
        rd = rdata;
        check("lit_ack_pulse", 32'(ack), 32'd1);
        @(negedge clk);
        check("lit_ack_drop", 32'(ack), 32'd0);
    endtask

    function automatic logic [6:0] seg_for_an_12af(input logic [3:0] a);
        case (a)
            4'b1110: return 7'b0001110;
            4'b1101: return 7'b0001000;
            4'b1011: return 7'b0100100;
            default: return 7'b1111001;
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        logic [3:0]  seen;
        int          dark;

        repeat (2) @(negedge clk);
        check("lit_reset_an", 32'(an), 32'hF);
        check("lit_reset_seg", 32'(seg), 32'h7F);
        check("lit_reset_ack", 32'(ack), 32'd0);
        check("lit_reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("lit_first_an", 32'(an), 32'b1110);
        check("lit_first_seg", 32'(seg), 32'b1000000);
        repeat (2) @(negedge clk);
        access(1'b0, BASE + 32'd4, 32'd0, rd);
        check("lit_ctrl_reset", rd, 32'h0000_000F);

        access(1'b1, BASE, 32'h0000_12AF, rd);
        seen = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (an == 4'b1110 || an == 4'b1101 || an == 4'b1011 || an == 4'b0111) begin
                seen = seen | ~an;
                check("lit_scan_seg", 32'(seg), 32'(seg_for_an_12af(an)));
            end
            @(negedge clk);
        end
        check("lit_scan_all_digits", 32'(seen), 32'hF);

        access(1'b1, BASE + 32'd4, 32'h5, rd);
        access(1'b0, BASE, 32'd0, rd);
        check("lit_data_readback", rd, 32'h0000_12AF);
        dark = 0;
        for (int i = 0; i < 16; i++) begin
            if (an == 4'hF && seg == 7'h7F) dark++;
            check("lit_mask_no_odd_digit", 32'(an == 4'b1101 || an == 4'b0111), 32'd0);
            @(negedge clk);
        end
        check("lit_mask_dark_cycles", 32'(dark), 32'd8);

        access(1'b1, 32'h0000_0100, 32'hFFFF, rd);
        access(1'b0, BASE, 32'd0, rd);
        check("lit_miss_no_write", rd, 32'h0000_12AF);
        access(1'b0, 32'h0000_0100, 32'd0, rd);
        check("lit_miss_read_zero", rd, 32'd0);

        access(1'b1, BASE + 32'd4, 32'h10F, rd);
        access(1'b0, BASE + 32'd4, 32'd0, rd);
        check("lit_blink_ctrl_read", rd, HAS_BLINK ? 32'h10F : 32'hF);
        dark = 0;
        for (int i = 0; i < 32; i++) begin
            if (an == 4'hF) dark++;
            @(negedge clk);
        end
        check("lit_blink_dark_cycles", 32'(dark), HAS_BLINK ? 32'd16 : 32'd0);
        access(1'b1, BASE + 32'd4, 32'hF, rd);
        check("lit_blink_off_lit", 32'(an != 4'hF), 32'd1);

        @(negedge clk);
        sel = 1'b1; data_rw = 1'b1; addr = BASE; wdata = 32'h8888; rst = 1'b1;
        @(negedge clk);
        check("lit_rst_abort_ack", 32'(ack), 32'd0);
        check("lit_rst_abort_an", 32'(an), 32'hF);
        sel = 1'b0; rst = 1'b0;
        access(1'b0, BASE, 32'd0, rd);
        check("lit_rst_abort_data", rd, 32'd0);
        access(1'b0, BASE + 32'd4, 32'd0, rd);
        check("lit_rst_abort_ctrl", rd, 32'hF);

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) == 0);
            sel = ($urandom_range(0, 2) == 0);
            data_rw = 1'($urandom);
            wdata = $urandom;
            case ($urandom_range(0, 3))
                0: addr = BASE;
                1: addr = BASE + 32'd4;
                2: addr = BASE + 32'($urandom_range(0, 7));
                default: addr = $urandom;
            endcase
        end
        @(negedge clk);
        rst = 1'b0; sel = 1'b0;
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
